// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the single memory port of the multicycle core between the
// instruction-fetch requester (i_*) and the load/store requester (d_*).
// In IDLE it picks a winner, latches that request onto the registered
// memory port, waits for m_ack, then pulses the winner's *_done for one
// cycle. The next grant is made in the IDLE cycle after that.
//
// Handshake: i_req/d_req are levels. A requester raises its request with
// its address/data stable and keeps it up until its *_done pulse. It drops
// the request on the clock edge that ends that pulse. m_req is registered
// and stays high, with m_we/m_addr/m_wdata frozen, until the cycle in which
// memory returns a single-cycle m_ack. m_rdata is sampled with that m_ack.
// m_ack is ignored in IDLE and DONE.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   i_req, i_addr          fetch request (level) and address
//   i_done, i_rdata        fetch completion pulse and fetched word
//   d_req, d_we, d_addr,   data request (level), store flag, address and
//   d_wdata                store data
//   d_done, d_rdata        data completion pulse and load word
//   m_req, m_we, m_addr,   registered memory request, write enable, address
//   m_wdata                and write data
//   m_ack, m_rdata         memory completion and read data
//   owner                  current owner (0 fetch, 1 data), valid while busy
//   busy                   arbiter is not IDLE
//   dbg_state              FSM state (0 IDLE, 1 BUSY, 2 DONE)
//   dbg_d_streak           consecutive data grants made while a fetch waited

module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4,
    localparam int SW          = $clog2(MAX_D_STREAK + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata,
    output logic          owner,
    output logic          busy,
    output logic [1:0]    dbg_state,
    output logic [SW-1:0] dbg_d_streak
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    state_t        state;
    logic [SW-1:0] d_streak;
    logic          fetch_wins;

    // Data has priority, except that a fetch which has already watched
    // MAX_D_STREAK data grants go by takes the next slot.
    assign fetch_wins = i_req && (!d_req || (d_streak == STREAK_MAX));

    assign busy         = (state != S_IDLE);
    assign dbg_state    = state;
    assign dbg_d_streak = d_streak;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            d_streak <= '0;
            owner    <= 1'b0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            // Completion pulses last exactly one cycle (the DONE cycle).
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        if (fetch_wins) begin
                            owner    <= 1'b0;
                            m_addr   <= i_addr;
                            m_we     <= 1'b0;
                            m_wdata  <= '0;
                            d_streak <= '0;
                        end else begin
                            owner   <= 1'b1;
                            m_addr  <= d_addr;
                            m_we    <= d_we;
                            m_wdata <= d_wdata;
                            // Only grants that make a fetch wait count
                            // towards its starvation limit.
                            if (i_req && (d_streak != STREAK_MAX)) begin
                                d_streak <= d_streak + SW'(1);
                            end
                        end
                        m_req <= 1'b1;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (m_ack) begin
                        if (owner) begin
                            d_rdata <= m_rdata;
                            d_done  <= 1'b1;
                        end else begin
                            i_rdata <= m_rdata;
                            i_done  <= 1'b1;
                        end
                        // Write enable and data are only meaningful while
                        // m_req is up; drop them with it.
                        m_req   <= 1'b0;
                        m_we    <= 1'b0;
                        m_wdata <= '0;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
